fifo_rd_pack: RTL

Downstream consumer of the FIFO controller/register-file pair. It pops narrow `DATA_WIDTH` words from the FIFO read port and reassembles consecutive pairs into one `2*DATA_WIDTH` word. The first word popped of each pair is the LSB half; the second is the MSB half, matching the write side's LSB/MSB split. Reassembled words go out on a registered valid/ready stream with full throughput: one pop per cycle and one wide word every two cycles.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_rd_pack_if.sv | 25 ++
 rtl/fifo_rd_pack.sv | 89 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared types for the FIFO-side blocks.
package fifo_pkg;

   typedef enum logic [1:0] {EMPTY, LO, OUT, OUT_LO} pack_state_t;

   function automatic logic state_has_word(pack_state_t s);
      return (s == OUT) || (s == OUT_LO);
   endfunction

   function automatic logic state_has_half(pack_state_t s);
      return (s == LO) || (s == OUT_LO);
   endfunction

endpackage

// File: rtl/fifo_rd_pack_if.sv
// FIFO read port plus the wide output stream of fifo_rd_pack.
interface fifo_rd_pack_if #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned COUNT_WIDTH = 16
);
   logic                      empty;
   logic [DATA_WIDTH-1:0]     r_data;
   logic                      rd;
   logic                      flush;
   logic [2*DATA_WIDTH-1:0]   out_data;
   logic                      out_valid;
   logic                      out_ready;
   logic                      half_pending;
   logic [COUNT_WIDTH-1:0]    words_out;

   modport master (
      input  empty, r_data, flush, out_ready,
      output rd, out_data, out_valid, half_pending, words_out
   );

   modport slave (
      output empty, r_data, flush, out_ready,
      input  rd, out_data, out_valid, half_pending, words_out
   );
endinterface

// File: rtl/fifo_rd_pack.sv
// Pops narrow FIFO entries and packs consecutive pairs into one wide word {msb, lsb}
// on a registered valid/ready stream.
module fifo_rd_pack
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input logic            clk,
   input logic            reset_n,
   fifo_rd_pack_if.master bus
);

   pack_state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0]      lo_q, lo_d;
   logic [2*DATA_WIDTH-1:0]    out_q, out_d;
   logic [COUNT_WIDTH-1:0]     cnt_q, cnt_d;
   logic                       rd, pop, hs, out_valid;

   assign out_valid = state_has_word(state_q);

   // A full OUT_LO can only pop if the held word leaves this same cycle.
   assign rd  = reset_n & ~bus.empty & ~bus.flush & ((state_q != OUT_LO) | bus.out_ready);
   assign pop = rd & ~bus.empty;
   assign hs  = out_valid & bus.out_ready;

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      out_d   = out_q;
      cnt_d   = cnt_q + COUNT_WIDTH'(hs);
      unique case (state_q)
         EMPTY: begin
            if (pop) begin
               state_d = LO;
               lo_d    = bus.r_data;
            end
         end
         LO: begin
            if (bus.flush) begin
               state_d = EMPTY;
            end else if (pop) begin
               state_d = OUT;
               out_d   = {bus.r_data, lo_q};
            end
         end
         OUT: begin
            if (pop) begin
               lo_d    = bus.r_data;
               state_d = hs ? LO : OUT_LO;
            end else if (hs) begin
               state_d = EMPTY;
            end
         end
         OUT_LO: begin
            if (bus.flush) begin
               state_d = hs ? EMPTY : OUT;
            end else if (pop) begin
               state_d = OUT;
               out_d   = {bus.r_data, lo_q};
            end else if (hs) begin
               state_d = LO;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         lo_q    <= '0;
         out_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.rd           = rd;
   assign bus.out_data     = out_q;
   assign bus.out_valid    = out_valid;
   assign bus.half_pending = state_has_half(state_q);
   assign bus.words_out    = cnt_q;

endmodule
